shift_add_mult32: RTL



---
 rtl/mult_pkg.sv | 15 +
 rtl/ripple_adder32.sv | 22 ++
 rtl/shift_add_mult32.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared encodings and sizes for the shift-and-add multiplier.
// FSM state encoding plus the fixed operand width and iteration count.
package mult_pkg;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_ITERS = 32;
   localparam int MULT_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/ripple_adder32.sv
// 32-bit ripple-carry adder shared by the sequential multiplier.
// Carry is chained bit by bit; cout is the carry out of bit 31.
module ripple_adder32 (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);

   always_comb begin
      logic c;
      c = cin;
      s = '0;
      for (int i = 0; i < 32; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/shift_add_mult32.sv
// Sequential 32x32 unsigned shift-and-add multiplier, 64-bit product.
// Optional overflow flag (product[63:32] != 0) under MULT_OVF_FLAG_EN.
module shift_add_mult32
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
`ifdef MULT_OVF_FLAG_EN
  ,output logic               ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [WIDTH-1:0]   add_y;
   logic [WIDTH-1:0]   add_s;
   logic               add_co;
   logic [2*WIDTH-1:0] shifted;

   assign add_y = lo_q[0] ? mcand_q : '0;

   ripple_adder32 u_adder (
      .x    (hi_q),
      .y    (add_y),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_co)
   );

   // {Cout,S,lo} shifted right by one; the dropped bit is lo[0]
   assign shifted = {add_co, add_s, lo_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            hi_d  = shifted[2*WIDTH-1:WIDTH];
            lo_d  = shifted[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MULT_ITERS - 1)) begin
               prod_d  = shifted;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

`ifdef MULT_OVF_FLAG_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && cnt_q == CNT_W'(MULT_ITERS - 1)) begin
         ovf_q <= |shifted[2*WIDTH-1:WIDTH];
      end
   end

   assign ovf = ovf_q;
`endif

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign product = prod_q;

endmodule
